// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encodings,
// owner IDs and the read-return tag layout.
package mem_port_arbiter_pkg;

   localparam int HOLD_W = 4;

   typedef enum logic {
      S_RR   = 1'b0,
      S_LOCK = 1'b1
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   typedef struct packed {
      logic dma;
      logic cpu;
   } rd_tag_t;

endpackage

// File: rtl/arb_grant_fsm.sv
// Grant generation for the CPU/DMA memory arbiter: round-robin with an optional
// DMA burst lock that yields one cycle to a waiting CPU every MAX_HOLD grants.
module arb_grant_fsm
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic c_req,
   input  logic d_req,
   input  logic d_lock,
   output logic c_gnt,
   output logic d_gnt
);

   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

   arb_state_t        state, state_nxt;
   owner_t            last, last_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_RR;
         last     <= OWN_DMA;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   // NOTE: every output of this block gets a default first; a path that
   // forgot one would otherwise infer a latch.
   always_comb begin
      c_gnt        = 1'b0;
      d_gnt        = 1'b0;
      state_nxt    = state;
      last_nxt     = last;
      hold_cnt_nxt = hold_cnt;

      // Nothing is granted while reset is asserted, so no write can slip out.
      if (!reset) begin
         case (state)
            S_RR: begin
               if (c_req && d_req) begin
                  c_gnt = (last == OWN_DMA);
                  d_gnt = ~c_gnt;
               end else begin
                  c_gnt = c_req;
                  d_gnt = d_req;
               end
               if (d_gnt && d_lock) begin
                  state_nxt    = S_LOCK;
                  hold_cnt_nxt = '0;
               end
            end

            S_LOCK: begin
               if (!d_req)
                  c_gnt = c_req;
               else if (c_req && (hold_cnt == HOLD_LIMIT))
                  c_gnt = 1'b1;
               else
                  d_gnt = 1'b1;

               if (!d_req || (d_gnt && !d_lock))
                  state_nxt = S_RR;

               // Starvation counter only runs while the CPU is actually waiting.
               if (!c_req || c_gnt)
                  hold_cnt_nxt = '0;
               else if (d_gnt)
                  hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end

            default: state_nxt = S_RR;
         endcase

         if (c_gnt)
            last_nxt = OWN_CPU;
         else if (d_gnt)
            last_nxt = OWN_DMA;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported unified memory shared by the multicycle CPU and a DMA/loader port:
// bus mux onto the memory macro plus per-port read-return registers.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_stall,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic          d_lock,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   rd_tag_t       rd_tag;
   logic [DW-1:0] c_rdata_q;
   logic [DW-1:0] d_rdata_q;

   arb_grant_fsm #(
      .MAX_HOLD (MAX_HOLD)
   ) u_grant_fsm (
      .clk    (clk),
      .reset  (reset),
      .c_req  (c_req),
      .d_req  (d_req),
      .d_lock (d_lock),
      .c_gnt  (c_gnt),
      .d_gnt  (d_gnt)
   );

   assign c_stall = c_req & ~c_gnt;

   // Idle bus is driven to all-zero so the macro sees no stray address/data.
   always_comb begin
      m_en    = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      if (c_gnt) begin
         m_en    = 1'b1;
         m_we    = c_we;
         m_addr  = c_addr;
         m_wdata = c_wdata;
      end else if (d_gnt) begin
         m_en    = 1'b1;
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_tag <= '0;
      end else begin
         rd_tag.dma <= d_gnt & ~d_we;
         rd_tag.cpu <= c_gnt & ~c_we;
      end
   end

   // A read granted just before reset must not complete inside the reset cycle.
   assign c_rvalid = rd_tag.cpu & ~reset;
   assign d_rvalid = rd_tag.dma & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         c_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (c_rvalid)
            c_rdata_q <= m_rdata;
         if (d_rvalid)
            d_rdata_q <= m_rdata;
      end
   end

   // Memory data is forwarded in the valid cycle, then held until the next read.
   assign c_rdata = c_rvalid ? m_rdata : c_rdata_q;
   assign d_rdata = d_rvalid ? m_rdata : d_rdata_q;

endmodule
